fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the 5-stage pipeline; replaces the single IF/ID instruction and PC+4 latch pair.
- Issues sequential fetch requests to instruction memory and tracks in-order responses of variable latency.
- Buffers up to DEPTH fetched instructions, each with its PC, and hands them to ID through a valid/ready handshake.
- A branch or jump redirect flushes all buffered and in-flight instructions and restarts fetch at the target.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fq_ring_buffer.sv | 48 ++++
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared defaults and entry type for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int FQ_DATA_WIDTH = 32;
    localparam int FQ_ADDR_WIDTH = 32;
    localparam int FQ_PC_STEP    = 4;
    localparam logic [FQ_ADDR_WIDTH-1:0] FQ_RESET_PC = '0;

    typedef struct packed {
        logic [FQ_ADDR_WIDTH-1:0] pc;
        logic [FQ_DATA_WIDTH-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ring_buffer.sv
// Circular storage for fetched {pc, instr} entries with flush.
module fq_ring_buffer
    import fetch_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   enq,
    input  entry_t                 enq_data,
    input  logic                   deq,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq) tail_ptr <= tail_ptr + PW'(1);
            if (deq) head_ptr <= head_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush && !rst) mem[tail_ptr] <= enq_data;
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: request issue, credits, drop and PC tracking.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DATA_WIDTH = FQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(FQ_RESET_PC),
    parameter int PC_STEP    = FQ_PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_inc_o,
    input  logic                  ready_i
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
    localparam logic [CW:0]           LIMIT = CW1'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] tail_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop;
    logic [CW-1:0]         count;
    logic [CW:0]           inflight;
    logic                  fire;
    logic                  discard;
    logic                  enq;
    logic                  deq;
    logic                  has_head;
    entry_t                enq_data;
    entry_t                head;

    // Credits cover both queued and in-flight entries, so a response
    // always finds a free slot.
    assign inflight    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o  = start & ~rst & ~redirect_i & (inflight < LIMIT);
    assign imem_addr_o = fetch_pc;
    assign fire        = imem_req_o & imem_gnt_i;

    assign discard  = imem_rvalid_i & (drop != '0);
    assign enq      = imem_rvalid_i & ~discard & ~redirect_i;
    assign enq_data = '{pc: tail_pc, instr: imem_rdata_i};

    assign has_head = (count != '0);
    assign valid_o  = has_head & ~redirect_i;
    assign deq      = valid_o & ready_i;
    assign instr_o  = has_head ? head.instr : '0;
    assign pc_o     = has_head ? head.pc : '0;
    assign pc_inc_o = has_head ? head.pc + STEP : '0;

    // On redirect every response still owed by memory becomes stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            tail_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= redirect_addr_i;
            tail_pc     <= redirect_addr_i;
            outstanding <= outstanding - CW'(imem_rvalid_i);
            drop        <= outstanding - CW'(imem_rvalid_i);
        end else begin
            if (fire) fetch_pc <= fetch_pc + STEP;
            if (enq)  tail_pc  <= tail_pc + STEP;
            outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid_i);
            drop        <= drop - CW'(discard);
        end
    end

    fq_ring_buffer #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order variable-latency memory.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_inc_o;
    logic        ready_i = 1'b1;

    int checks = 0;
    int fails = 0;
    int lat = 1;
    int cyc = 0;
    int grants = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .pc_inc_o        (pc_inc_o),
        .ready_i         (ready_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && imem_rvalid_i)
            assert (dut.outstanding != '0)
                else $error("protocol: rvalid with no outstanding request");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // One clock: record a grant, then present the next due response.
    task automatic step();
        logic        f;
        logic [31:0] a;
        #1;
        f = imem_req_o && imem_gnt_i;
        a = imem_addr_o;
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            pend.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end else begin
            if (f) begin
                pend.push_back('{addr: a, due: cyc + lat - 1});
                grants++;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word(pend[0].addr);
                pend.delete(0);
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        redirect_i = 1'b0;
        redirect_addr_i = '0;
        ready_i = 1'b1;
        imem_gnt_i = 1'b1;
        lat = 1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (valid_o !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: valid_o=%b want 1", name, valid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        step();
        step();
        checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
        checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        checks++; if (instr_o !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", instr_o); end
        checks++; if (pc_o !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", pc_o); end
        checks++; if (pc_inc_o !== 32'h0) begin fails++; $display("FAIL rst_pc_inc: got %h want 0", pc_inc_o); end
        checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin fails++; $display("FAIL rst_release_req: got %b want 1", imem_req_o); end
    endtask

    task automatic test_stream();
        do_reset();
        start = 1'b1;
        #1;
        checks++; if (imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin fails++; $display("FAIL stream_c1: addr=%h valid=%b want 0/0", imem_addr_o, valid_o); end
        step();
        checks++; if (imem_addr_o !== 32'h4 || valid_o !== 1'b0) begin fails++; $display("FAIL stream_c2: addr=%h valid=%b want 4/0", imem_addr_o, valid_o); end
        step();
        checks++; if (imem_addr_o !== 32'h8) begin fails++; $display("FAIL stream_c3_addr: got %h want 8", imem_addr_o); end
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin fails++; $display("FAIL stream_first: valid=%b pc=%h want 1/0", valid_o, pc_o); end
        checks++; if (pc_inc_o !== 32'h4) begin fails++; $display("FAIL stream_pc_inc: got %h want 4", pc_inc_o); end
        checks++; if (instr_o !== word(32'h0)) begin fails++; $display("FAIL stream_instr: got %h want %h", instr_o, word(32'h0)); end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4 * k)) begin
                fails++;
                $display("FAIL stream_rate: valid=%b pc=%h want 1/%h", valid_o, pc_o, 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start = 1'b1;
        ready_i = 1'b0;
        grants = 0;
        repeat (10) step();
        checks++; if (grants != 4) begin fails++; $display("FAIL bp_grants: got %0d want 4", grants); end
        checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL bp_req: got %b want 0", imem_req_o); end
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin fails++; $display("FAIL bp_head: valid=%b pc=%h want 1/0", valid_o, pc_o); end
        ready_i = 1'b1;
        grants = 0;
        step();
        ready_i = 1'b0;
        repeat (6) step();
        checks++; if (grants != 1) begin fails++; $display("FAIL bp_one_more: got %0d want 1", grants); end
        checks++; if (imem_addr_o !== 32'h14) begin fails++; $display("FAIL bp_addr: got %h want 14", imem_addr_o); end
        ready_i = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4 * k) || instr_o !== word(32'(4 * k))) begin
                fails++;
                $display("FAIL bp_order: valid=%b pc=%h instr=%h want 1/%h/%h", valid_o, pc_o, instr_o, 32'(4 * k), word(32'(4 * k)));
            end
            step();
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        start = 1'b1;
        lat = 3;
        step();
        step();
        checks++; if (dut.outstanding !== 3'd2) begin fails++; $display("FAIL rf_inflight: got %0d want 2", dut.outstanding); end
        redirect_i = 1'b1;
        redirect_addr_i = 32'h100;
        #1;
        checks++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin fails++; $display("FAIL rf_gate: req=%b valid=%b want 0/0", imem_req_o, valid_o); end
        step();
        redirect_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin fails++; $display("FAIL rf_addr: req=%b addr=%h want 1/100", imem_req_o, imem_addr_o); end
        wait_valid("rf");
        checks++; if (pc_o !== 32'h100 || instr_o !== word(32'h100)) begin fails++; $display("FAIL rf_head: pc=%h instr=%h want 100/%h", pc_o, instr_o, word(32'h100)); end
        step();
        checks++; if (pc_o !== 32'h104 || instr_o !== word(32'h104)) begin fails++; $display("FAIL rf_next: pc=%h instr=%h want 104/%h", pc_o, instr_o, word(32'h104)); end
    endtask

    task automatic test_redirect_deq();
        do_reset();
        start = 1'b1;
        step();
        step();
        checks++; if (valid_o !== 1'b1) begin fails++; $display("FAIL rd_pre: valid=%b want 1", valid_o); end
        redirect_i = 1'b1;
        redirect_addr_i = 32'h200;
        #1;
        checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rd_valid: got %b want 0", valid_o); end
        step();
        redirect_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || dut.u_ring.count !== 3'd0) begin fails++; $display("FAIL rd_empty: valid=%b count=%0d want 0/0", valid_o, dut.u_ring.count); end
        checks++; if (imem_addr_o !== 32'h200) begin fails++; $display("FAIL rd_addr: got %h want 200", imem_addr_o); end
        wait_valid("rd");
        checks++; if (pc_o !== 32'h200 || instr_o !== word(32'h200)) begin fails++; $display("FAIL rd_head: pc=%h instr=%h want 200/%h", pc_o, instr_o, word(32'h200)); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        start = 1'b1;
        redirect_i = 1'b1;
        redirect_addr_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        #1;
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr_o); end
        step();
        checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL wrap_addr1: got %h want 0", imem_addr_o); end
        wait_valid("wrap");
        checks++; if (pc_o !== 32'hFFFF_FFFC || pc_inc_o !== 32'h0) begin fails++; $display("FAIL wrap_head: pc=%h inc=%h want fffffffc/0", pc_o, pc_inc_o); end
        step();
        checks++; if (pc_o !== 32'h0 || pc_inc_o !== 32'h4) begin fails++; $display("FAIL wrap_next: pc=%h inc=%h want 0/4", pc_o, pc_inc_o); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        start = 1'b1;
        ready_i = 1'b0;
        repeat (4) step();
        checks++; if (dut.u_ring.count !== 3'd3 || dut.outstanding !== 3'd1) begin fails++; $display("FAIL rm_pre: count=%0d out=%0d want 3/1", dut.u_ring.count, dut.outstanding); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rm_valid: got %b want 0", valid_o); end
        checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL rm_addr: got %h want 0", imem_addr_o); end
        checks++; if (dut.outstanding !== 3'd0) begin fails++; $display("FAIL rm_out: got %0d want 0", dut.outstanding); end
        ready_i = 1'b1;
        wait_valid("rm");
        checks++; if (pc_o !== 32'h0 || instr_o !== word(32'h0)) begin fails++; $display("FAIL rm_head: pc=%h instr=%h want 0/%h", pc_o, instr_o, word(32'h0)); end
    endtask

    task automatic test_start_low();
        do_reset();
        start = 1'b1;
        lat = 3;
        step();
        step();
        start = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL sl_req: got %b want 0", imem_req_o); end
        wait_valid("sl");
        checks++; if (pc_o !== 32'h0) begin fails++; $display("FAIL sl_first: pc=%h want 0", pc_o); end
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h4) begin fails++; $display("FAIL sl_second: valid=%b pc=%h want 1/4", valid_o, pc_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL sl_drained: valid=%b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_deq();
        test_pc_wrap();
        test_rst_mid();
        test_start_low();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
